// File: rtl/diff_patch_pkg.sv
// Shared definitions for the diff / diff_patch bit-difference units.
// Holds the FSM encoding, default widths and the saturating counter helper.
package diff_patch_pkg;

  localparam int DP_WIDTH = 32;
  localparam int DP_IDXW  = 5;
  localparam int DP_CNTW  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } dp_state_e;

  // Counters of up to 16 bits share this helper; callers cast in and out.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] cap);
    return (v >= cap) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/diff_patch_if.sv
// Control, index-stream and result bundle for diff_patch.
// master = control/write-back side, slave = diff_patch.
interface diff_patch_if import diff_patch_pkg::*; #(
  parameter int WIDTH = DP_WIDTH,
  parameter int IDXW  = DP_IDXW,
  parameter int CNTW  = DP_CNTW
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic             no_idx;
  logic             abort;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDXW-1:0]  idx;
  logic             idx_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ifequal;
  logic [CNTW-1:0]  flips;
  logic             err;
  logic             busy;

  modport master (
    output start, base, no_idx, abort, idx_valid, idx, idx_last, out_ready,
    input  idx_ready, out_valid, out, ifequal, flips, err, busy
  );

  modport slave (
    input  start, base, no_idx, abort, idx_valid, idx, idx_last, out_ready,
    output idx_ready, out_valid, out, ifequal, flips, err, busy
  );
endinterface

// File: rtl/diff_bit_toggle.sv
// Combinational single-bit toggle: res = word ^ (1 << idx), flagging idx >= WIDTH.
// An out-of-range index matches no bit, so the word passes through unchanged.
module diff_bit_toggle #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IDXW-1:0]  idx,
  output logic [WIDTH-1:0] res,
  output logic             oor
);
  assign oor = 32'(idx) >= WIDTH;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign res[b] = word[b] ^ (32'(idx) == b);
  end
endmodule

// File: rtl/diff_patch.sv
// Rebuilds a target word from a base word and a stream of differing-bit indices.
// IDLE -> ACC (one index per cycle) -> DONE (result held until out handshake).
module diff_patch import diff_patch_pkg::*; #(
  parameter int WIDTH = DP_WIDTH,
  parameter int IDXW  = DP_IDXW,
  parameter int CNTW  = DP_CNTW
) (
  input logic         clk,
  input logic         rst_n,
  diff_patch_if.slave bus
);
  localparam logic [15:0] FLIP_MAX = 16'((1 << CNTW) - 1);

  dp_state_e        state;
  logic [WIDTH-1:0] base_q, acc, tog, out_q;
  logic [CNTW-1:0]  flips_q;
  logic             ifequal_q, err_q, oor;

  diff_bit_toggle #(.WIDTH(WIDTH), .IDXW(IDXW)) u_tog (
    .word (acc),
    .idx  (bus.idx),
    .res  (tog),
    .oor  (oor)
  );

  // abort masks idx_ready so a same-cycle index is never consumed.
  assign bus.idx_ready = (state == ST_ACC) && !bus.abort;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out       = out_q;
  assign bus.ifequal   = ifequal_q;
  assign bus.flips     = flips_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      acc       <= '0;
      out_q     <= '0;
      flips_q   <= '0;
      ifequal_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (bus.abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          base_q  <= bus.base;
          acc     <= bus.base;
          flips_q <= '0;
          err_q   <= 1'b0;
          if (bus.no_idx) begin
            out_q     <= bus.base;
            ifequal_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            state <= ST_ACC;
          end
        end
        ST_ACC: if (bus.idx_valid) begin
          acc     <= tog;
          flips_q <= CNTW'(sat_inc(16'(flips_q), FLIP_MAX));
          if (oor) err_q <= 1'b1;
          // Result registered on the last index so it stays put after DONE.
          if (bus.idx_last) begin
            out_q     <= tog;
            ifequal_q <= (tog == base_q);
            state     <= ST_DONE;
          end
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_diff_patch.sv
// Directed bench for diff_patch: 32-bit instance for main flows, 24-bit instance for range checks.
module tb_diff_patch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  diff_patch_if d ();
  diff_patch_if #(.WIDTH(24), .IDXW(5), .CNTW(6)) e ();

  diff_patch u_dut32 (.clk(clk), .rst_n(rst_n), .bus(d));
  diff_patch #(.WIDTH(24), .IDXW(5), .CNTW(6)) u_dut24 (.clk(clk), .rst_n(rst_n), .bus(e));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic [31:0] b, input logic ni);
    d.start = 1'b1; d.base = b; d.no_idx = ni;
    step();
    d.start = 1'b0; d.no_idx = 1'b0;
  endtask

  task automatic idx32(input int i, input logic last);
    d.idx_valid = 1'b1; d.idx = 5'(i); d.idx_last = last;
    step();
    d.idx_valid = 1'b0; d.idx_last = 1'b0;
  endtask

  task automatic accept32();
    d.out_ready = 1'b1;
    step();
    d.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {d.start, d.no_idx, d.abort, d.idx_valid, d.idx_last, d.out_ready} = '0;
    d.base = '0; d.idx = '0;
    {e.start, e.no_idx, e.abort, e.idx_valid, e.idx_last, e.out_ready} = '0;
    e.base = '0; e.idx = '0;

    // reset state
    #3;
    chk("rst_out",       d.out, 0);
    chk("rst_ifequal",   32'(d.ifequal), 0);
    chk("rst_flips",     32'(d.flips), 0);
    chk("rst_err",       32'(d.err), 0);
    chk("rst_out_valid", 32'(d.out_valid), 0);
    chk("rst_idx_ready", 32'(d.idx_ready), 0);
    chk("rst_busy",      32'(d.busy), 0);
    #9 rst_n = 1'b1;
    step();

    // single index
    start32(32'h0000_00F0, 1'b0);
    chk("t1_idx_ready", 32'(d.idx_ready), 1);
    chk("t1_no_valid",  32'(d.out_valid), 0);
    idx32(3, 1'b1);
    chk("t1_out_valid", 32'(d.out_valid), 1);
    chk("t1_out",       d.out, 32'h0000_00F8);
    chk("t1_ifequal",   32'(d.ifequal), 0);
    chk("t1_flips",     32'(d.flips), 1);
    chk("t1_err",       32'(d.err), 0);
    accept32();
    chk("t1_idle",      32'(d.busy), 0);
    chk("t1_out_hold",  d.out, 32'h0000_00F8);

    // duplicate index toggles back
    start32(32'hFFFF_FFFF, 1'b0);
    idx32(31, 1'b0);
    idx32(31, 1'b1);
    chk("t2_out",     d.out, 32'hFFFF_FFFF);
    chk("t2_ifequal", 32'(d.ifequal), 1);
    chk("t2_flips",   32'(d.flips), 2);
    chk("t2_err",     32'(d.err), 0);
    accept32();

    // zero indices
    start32(32'h1234_5678, 1'b1);
    chk("t3_out_valid", 32'(d.out_valid), 1);
    chk("t3_out",       d.out, 32'h1234_5678);
    chk("t3_ifequal",   32'(d.ifequal), 1);
    chk("t3_flips",     32'(d.flips), 0);
    accept32();

    // back-to-back indices then backpressure; a start in DONE must be ignored
    start32(32'h0, 1'b0);
    d.idx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d.idx = 5'(i); d.idx_last = (i == 2);
      chk("t4_idx_ready", 32'(d.idx_ready), 1);
      step();
    end
    d.idx_valid = 1'b0; d.idx_last = 1'b0;
    chk("t4_out", d.out, 32'h0000_0007);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin d.start = 1'b1; d.base = 32'hDEAD_BEEF; d.no_idx = 1'b1; end
      if (i == 3) begin d.start = 1'b0; d.no_idx = 1'b0; end
      step();
      chk("t4_hold_valid", 32'(d.out_valid), 1);
      chk("t4_hold_out",   d.out, 32'h0000_0007);
    end
    accept32();
    chk("t4_idle",      32'(d.busy), 0);
    chk("t4_idle_nov",  32'(d.out_valid), 0);

    // abort after 2 of 4 indices
    start32(32'h0, 1'b0);
    idx32(0, 1'b0);
    idx32(1, 1'b0);
    d.idx_valid = 1'b1; d.idx = 5'd2; d.abort = 1'b1;
    #1;
    chk("t5_abort_rdy", 32'(d.idx_ready), 0);
    step();
    d.abort = 1'b0; d.idx_valid = 1'b0;
    chk("t5_idle",      32'(d.busy), 0);
    chk("t5_no_valid",  32'(d.out_valid), 0);
    chk("t5_no_rdy",    32'(d.idx_ready), 0);
    start32(32'h0, 1'b0);
    idx32(5, 1'b1);
    chk("t5_clean_out",   d.out, 32'h0000_0020);
    chk("t5_clean_flips", 32'(d.flips), 1);
    chk("t5_clean_eq",    32'(d.ifequal), 0);
    accept32();

    // flip counter saturates; every bit toggled twice lands back on base
    start32(32'h0, 1'b0);
    for (int i = 0; i < 70; i++) idx32(i % 32, i == 69 ? 1'b1 : 1'b0);
    // indices 64..69 re-toggle bits 0..5
    chk("t6_sat_flips", 32'(d.flips), 63);
    chk("t6_sat_out",   d.out, 32'h0000_003F);
    accept32();

    // reset mid-operation
    start32(32'h0000_AAAA, 1'b0);
    idx32(0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rst_out",   d.out, 0);
    chk("t7_rst_flips", 32'(d.flips), 0);
    chk("t7_rst_busy",  32'(d.busy), 0);
    chk("t7_rst_rdy",   32'(d.idx_ready), 0);
    #1 rst_n = 1'b1;
    step();

    // 24-bit instance: out-of-range and top in-range index
    e.start = 1'b1; e.base = '0;
    step();
    e.start = 1'b0;
    e.idx_valid = 1'b1; e.idx = 5'd30; e.idx_last = 1'b1;
    step();
    e.idx_valid = 1'b0; e.idx_last = 1'b0;
    chk("t8_oor_valid", 32'(e.out_valid), 1);
    chk("t8_oor_out",   32'(e.out), 0);
    chk("t8_oor_err",   32'(e.err), 1);
    chk("t8_oor_flips", 32'(e.flips), 1);
    chk("t8_oor_eq",    32'(e.ifequal), 1);
    e.out_ready = 1'b1;
    step();
    e.out_ready = 1'b0;
    e.start = 1'b1; e.base = '0;
    step();
    e.start = 1'b0;
    chk("t8_err_clr",   32'(e.err), 0);
    e.idx_valid = 1'b1; e.idx = 5'd23; e.idx_last = 1'b1;
    step();
    e.idx_valid = 1'b0; e.idx_last = 1'b0;
    chk("t8_top_out",   32'(e.out), 32'h0080_0000);
    chk("t8_top_err",   32'(e.err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/diff_patch.md
Name: diff_patch

Overview:
- Inverse of the `diff` bit-difference unit. `diff` reduces two words to the index of a differing bit; this block takes a base word plus a stream of bit indices and rebuilds the target word by toggling one bit per accepted index.
- Sits beside the ALU as a multi-cycle unit. It is fed by the control path and drains into the register write-back path through a valid/ready handshake.

Parameters:
- WIDTH, 32, data word width in bits.
- IDXW, 5, bit-index width; must equal ceil(log2(WIDTH)).
- CNTW, 6, width of the flip counter; saturates at 2^CNTW-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- base  in  WIDTH  base word, latched on the start handshake.
- no_idx  in  1  qualifies start: the operation has zero indices.
- abort  in  1  synchronous cancel; returns to IDLE.
- idx_valid  in  1  index available.
- idx_ready  out  1  block accepts an index this cycle.
- idx  in  IDXW  bit position to toggle.
- idx_last  in  1  marks the final index of the operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  patched word.
- ifequal  out  1  patched word equals base.
- flips  out  CNTW  number of indices accepted (saturating).
- err  out  1  sticky: an index ≥ WIDTH was received in this operation.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: out, ifequal, flips, err, out_valid, idx_ready, busy. Internal base copy and accumulator cleared.
- State IDLE:
  - idx_ready=0, out_valid=0.
  - start=1 and no_idx=0: latch base into base_q and acc; flips=0, err=0; go to ACC next cycle.
  - start=1 and no_idx=1: latch as above; go directly to DONE. Result is out=base, ifequal=1, flips=0.
- State ACC:
  - idx_ready=1.
  - On idx_valid&&idx_ready:
    - idx<WIDTH: acc[idx] toggles and flips increments (saturating).
    - idx≥WIDTH: acc is unchanged, err set, flips still increments.
    - idx_last=1: go to DONE next cycle.
  - Throughput: one index per cycle, no bubbles.
- State DONE:
  - out_valid=1, out=acc, ifequal=(acc==base_q), flips/err held.
  - Latency: the result is valid the cycle after the last index handshake, or the cycle after start when no_idx=1.
  - On out_valid&&out_ready: go to IDLE. out, ifequal, flips and err keep their last values until the next start.
  - Result is held stable while out_ready=0; no timeout.
- Duplicate indices toggle the bit back, so ifequal is computed by comparison, not from flips==0.
- start asserted outside IDLE is ignored, with no queuing. After the DONE handshake there is a mandatory one-cycle IDLE bubble before the next start is sampled.
- abort:
  - Synchronous, any state: go to IDLE next cycle; out_valid=0, idx_ready=0.
  - An index presented in the same cycle is not consumed (idx_ready forced 0 when abort=1).
  - abort has priority over start, the idx handshake and the out handshake.
- rst_n asserted mid-operation: immediate return to reset values; the partial result is lost.
- idx_ready and out_valid are registered-state decodes only. idx_valid must not combinationally drive idx_ready, and out_ready must not drive out_valid.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2);
  - WIDTH/IDXW defaults shared with `diff`;
  - the saturating-increment function.
- One sub-module, diff_bit_toggle: combinational, maps (word, idx) to (word ^ (1<<idx), out_of_range). It is also reusable for a future `diff` self-check.
- FSM, accumulator and counters stay in diff_patch.

Test Plan:
- Single index: base=32'h0000_00F0, no_idx=0, idx=3 with idx_last=1 → out=32'h0000_00F8, ifequal=0, flips=1, out_valid one cycle after the idx handshake.
- Duplicate index: base=32'hFFFF_FFFF, idx=31 then idx=31 (last) → out=32'hFFFF_FFFF, ifequal=1, flips=2, err=0.
- Zero indices: start with no_idx=1, base=32'h1234_5678 → DONE next cycle, out=32'h1234_5678, ifequal=1, flips=0.
- Backpressure: idx 0,1,2 back-to-back (idx_valid held high), then out_ready=0 for 5 cycles → idx_ready high 3 consecutive cycles, out=32'h0000_0007 with base=0, out held stable, IDLE one cycle after out_ready=1.
- Abort and reset mid-operation:
  - abort after 2 of 4 indices → idx_ready=0 that cycle, IDLE next cycle, no out_valid;
  - a new start afterwards returns a clean result;
  - rst_n pulsed low in ACC → all outputs 0 immediately.
- Out-of-range index with WIDTH=24, IDXW=5: base=0, idx=30 (last) → out=0, err=1, flips=1, ifequal=1.
